// File: rtl/mips_defs_pkg.sv
// Constants shared by the data memory, decoder and writeback stage of the MIPS core.
package mips_defs;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  localparam logic [3:0] MEM_LW  = 4'b0000;
  localparam logic [3:0] MEM_SW  = 4'b0001;
  localparam logic [3:0] MEM_LH  = 4'b0010;
  localparam logic [3:0] MEM_LB  = 4'b0011;
  localparam logic [3:0] MEM_LHU = 4'b0100;
  localparam logic [3:0] MEM_LBU = 4'b0101;
  localparam logic [3:0] MEM_SH  = 4'b0110;
  localparam logic [3:0] MEM_SB  = 4'b0111;
  localparam logic [3:0] MEM_NO  = 4'b1000;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;
  localparam logic [1:0] WB_RSVD = 2'b11;

  localparam logic [1:0] EXC_NONE  = 2'b00;
  localparam logic [1:0] EXC_LOAD  = 2'b10;
  localparam logic [1:0] EXC_STORE = 2'b11;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        reg_write;
    logic [4:0]  dst;
    logic [31:0] data;
    logic [1:0]  exc;
  } wb_bundle_t;

endpackage

// File: rtl/mem_wb_stage_load_extender.sv
// Combinational sub-word load extraction (little-endian) and halfword alignment check.
module load_extender
  import mips_defs::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  addr_lo,
  input  logic [3:0]  code,
  output logic [31:0] ext_data,
  output logic        misaligned_half
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = mem_rdata[8*addr_lo +: 8];
    half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (code)
      MEM_LB:  ext_data = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: ext_data = {24'h0, byte_sel};
      MEM_LH:  ext_data = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: ext_data = {16'h0, half_sel};
      default: ext_data = mem_rdata;
    endcase
    misaligned_half = ((code == MEM_LH) || (code == MEM_LHU)) && addr_lo[0];
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load extension, exception merge, writeback mux, one-cycle latency.
module mem_wb_stage
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid_in,
  input  logic [31:0] pc_in,
  input  logic [3:0]  code,
  input  logic [31:0] addr,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] alu_result,
  input  logic [1:0]  wb_sel,
  input  logic        reg_write_in,
  input  logic [4:0]  dst_in,
  input  logic [1:0]  addr_exc_in,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic        reg_write_out,
  output logic [4:0]  dst_out,
  output logic [31:0] wb_data,
  output logic [1:0]  exc_out
);

  localparam wb_bundle_t BUBBLE = '{valid: 1'b0, pc: RESET_PC, reg_write: 1'b0,
                                    dst: 5'd0, data: 32'd0, exc: EXC_NONE};

  logic [31:0] ext_data;
  logic        misaligned_half;
  logic [1:0]  exc_cap;
  wb_bundle_t  wb_nxt, wb_q;

  // Only the byte offset matters here; the word index went to the data memory.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[31:2];

  load_extender u_ext (
    .mem_rdata       (mem_rdata),
    .addr_lo         (addr[1:0]),
    .code            (code),
    .ext_data        (ext_data),
    .misaligned_half (misaligned_half)
  );

  always_comb begin
    exc_cap = EXC_NONE;
    if (valid_in) begin
      if (addr_exc_in != EXC_NONE)  exc_cap = addr_exc_in;
      else if (misaligned_half)     exc_cap = EXC_LOAD;
    end

    wb_nxt.valid     = valid_in;
    wb_nxt.pc        = pc_in;
    wb_nxt.dst       = dst_in;
    wb_nxt.exc       = exc_cap;
    wb_nxt.reg_write = reg_write_in && valid_in && (exc_cap == EXC_NONE) && (dst_in != 5'd0);
    case (wb_sel)
      WB_LOAD: wb_nxt.data = ext_data;
      WB_LINK: wb_nxt.data = pc_in + 32'd8;
      default: wb_nxt.data = alu_result;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) wb_q <= BUBBLE;
    else if (!stall)    wb_q <= wb_nxt;
  end

  assign valid_out     = wb_q.valid;
  assign pc_out        = wb_q.pc;
  assign reg_write_out = wb_q.reg_write;
  assign dst_out       = wb_q.dst;
  assign wb_data       = wb_q.data;
  assign exc_out       = wb_q.exc;

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-to-writeback pipeline stage of the five-stage MIPS core. Sits directly downstream of the data memory. Each cycle it captures the raw 32-bit word the data memory reads, plus the memory-stage control bundle. It then extracts and extends the addressed byte or halfword, checks sub-word load alignment, selects the writeback value, and presents a registered writeback bundle to the register file and the forwarding network.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_3000: value of `pc_out` after reset or flush.

Ports (clock and reset first):
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold all stage registers.
- `flush`  in  1  insert a bubble.
- `valid_in`  in  1  memory-stage slot holds a real instruction.
- `pc_in`  in  32  PC of the memory-stage instruction.
- `code`  in  4  memory-op code: lw 0000, sw 0001, lh 0010, lb 0011, lhu 0100, lbu 0101, sh 0110, sb 0111, no 1000.
- `addr`  in  32  effective address, same value as driven to the data memory.
- `mem_rdata`  in  32  word read from the data memory at `addr[13:2]`.
- `alu_result`  in  32  ALU result of the memory-stage instruction.
- `wb_sel`  in  2  writeback source: 00 ALU, 01 load, 10 PC+8, 11 reserved (behaves as 00).
- `reg_write_in`  in  1  instruction writes a GPR.
- `dst_in`  in  5  destination GPR.
- `addr_exc_in`  in  2  exception code from the data memory: 00 none, 10 load, 11 store.
- `valid_out`  out  1  writeback slot valid.
- `pc_out`  out  32  registered PC.
- `reg_write_out`  out  1  registered GPR write enable, after suppression.
- `dst_out`  out  5  registered destination.
- `wb_data`  out  32  registered writeback value.
- `exc_out`  out  2  registered exception code.

## Operation
- Load extraction uses `addr[1:0]` as the byte offset, little-endian.
  - lb/lbu: byte `addr[1:0]`, sign- or zero-extended to 32 bits.
  - lh/lhu: halfword `addr[1]`, sign- or zero-extended to 32 bits.
  - lw: `mem_rdata` passes through unchanged.
  - Any other code: extracted value is `mem_rdata`, but it is only used when `wb_sel`=01.
- Alignment check (this stage's own):
  - lh or lhu with `addr[0]`=1 raises load exception 10.
  - Word checks come from `addr_exc_in`.
  - Captured exception = `addr_exc_in` if nonzero, else the local code.
- Writeback value:
  - `wb_sel`=00 or 11: `alu_result`.
  - `wb_sel`=01: extracted load value.
  - `wb_sel`=10: `pc_in`+8, modulo 2^32.
- `reg_write_out` = `reg_write_in` & `valid_in` & (captured exception = 00) & (`dst_in` ≠ 0).
- Exceptions are captured only when `valid_in`=1; otherwise `exc_out` captures 00.

## Timing
- Latency: exactly one cycle from memory-stage inputs to every output. Nothing is combinational from inputs to outputs.
- Priority at each rising edge: `reset` > `flush` > `stall` > normal capture.
- Reset and flush values: `valid_out`=0, `pc_out`=`RESET_PC`, `reg_write_out`=0, `dst_out`=0, `wb_data`=0, `exc_out`=00.
- Flush together with stall: flush wins and a bubble is loaded.
- Stall: all outputs hold their values. Inputs presented during the stall are ignored, not queued.
- Reset asserted mid-stall clears the stage on the next edge.
- Exactly one capture per non-stalled edge; there is no multi-cycle state.

## Structure
- Shared package `mips_defs`:
  - memory-op codes (the nine 4-bit values above)
  - `wb_sel` encodings
  - exception codes 00/10/11
  - `RESET_PC` default
- These constants are shared with the data memory and the decoder.
- Sub-module `load_extender`: purely combinational. Inputs `mem_rdata`, `addr[1:0]`, `code`; outputs the extended value and a misaligned-half flag.
- Stage registers and all muxing live in `mem_wb_stage`.

## Test plan
- **Reset:** hold `reset` 2 cycles with arbitrary inputs -> `valid_out`=0, `pc_out`=32'h3000, `wb_data`=0, `exc_out`=00.
- **Byte and half extension:** `mem_rdata`=32'h80F1_7F82, `wb_sel`=01, `valid_in`=1.
  - lb at `addr`=..01 -> `wb_data`=32'h0000_007F
  - lb at ..00 -> 32'hFFFF_FF82
  - lbu at ..00 -> 32'h0000_0082
  - lh at ..10 -> 32'hFFFF_80F1
  - lhu at ..10 -> 32'h0000_80F1
  - each appears one cycle after its input.
- **Misaligned half:** lh at `addr`=32'h0000_0103, `reg_write_in`=1, `dst_in`=8 -> `exc_out`=10, `reg_write_out`=0.
- **Upstream word exception:** lw with `addr_exc_in`=10 -> `exc_out`=10, `reg_write_out`=0. Same with `valid_in`=0 -> `exc_out`=00.
- **Link and $0:**
  - `wb_sel`=10, `pc_in`=32'h0000_3010, `dst_in`=31 -> `wb_data`=32'h0000_3018, `reg_write_out`=1.
  - `dst_in`=0 -> `reg_write_out`=0.
- **Stall and flush:**
  - stall 3 cycles while inputs change -> outputs frozen.
  - assert `flush`+`stall` together -> next cycle bubble (`valid_out`=0, `pc_out`=32'h3000).
